// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with a PC alias and a pending-write scoreboard.
//
// Address 2^ADDR_W-1 (R_PC) is not stored. Reads of it return the pc input,
// and writes to it are discarded but reported on pcwrite. Every other
// address is a DATA_W-bit register.
// A busy bit per stored register marks a register that has been reserved by
// a producer and not yet written.
//
// Ports:
//   clk       - rising-edge clock for all state
//   reset     - synchronous active-high reset; clears registers, busy bits and flags
//   ra        - NRD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd        - NRD packed read data, same order as ra (combinational)
//   we        - NWR write enables
//   wa        - NWR packed write addresses
//   wd        - NWR packed write data
//   pc        - value returned for reads of R_PC
//   rsv_en    - reserve rsv_addr as pending-write at the edge
//   rsv_addr  - register to reserve (R_PC ignored)
//   busy      - per read port: addressed register is reserved and not yet written
//   wconflict - one cycle after two or more enabled writes hit one address
//   pcwrite   - one cycle after any enabled write targeted R_PC
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NRD    = 3,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NRD*ADDR_W-1:0]  ra,
    output logic [NRD*DATA_W-1:0]  rd,
    input  logic [NWR-1:0]         we,
    input  logic [NWR*ADDR_W-1:0]  wa,
    input  logic [NWR*DATA_W-1:0]  wd,
    input  logic [DATA_W-1:0]      pc,
    input  logic                   rsv_en,
    input  logic [ADDR_W-1:0]      rsv_addr,
    output logic [NRD-1:0]         busy,
    output logic                   wconflict,
    output logic                   pcwrite
);

    localparam int NREG = (1 << ADDR_W) - 1;
    localparam logic [ADDR_W-1:0] R_PC = {ADDR_W{1'b1}};

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy_bits;

    logic [ADDR_W-1:0] wa_a [NWR];
    logic [DATA_W-1:0] wd_a [NWR];

    logic conflict;
    logic pc_hit;

    for (genvar j = 0; j < NWR; j++) begin : g_wsplit
        assign wa_a[j] = wa[j*ADDR_W +: ADDR_W];
        assign wd_a[j] = wd[j*DATA_W +: DATA_W];
    end

    // Conflict covers any shared address, R_PC included.
    always_comb begin
        conflict = 1'b0;
        pc_hit   = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && wa_a[j] == R_PC) begin
                pc_hit = 1'b1;
            end
            for (int k = j + 1; k < NWR; k++) begin
                if (we[j] && we[k] && wa_a[j] == wa_a[k]) begin
                    conflict = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wconflict <= 1'b0;
            pcwrite   <= 1'b0;
        end else begin
            wconflict <= conflict;
            pcwrite   <= pc_hit;
        end
    end

    // One storage slot per stored address. Scanning the write ports in
    // ascending order lets the highest-index enabled port win.
    for (genvar r = 0; r < NREG; r++) begin : g_reg
        localparam logic [ADDR_W-1:0] ADDR = ADDR_W'(r);

        logic              hit;
        logic [DATA_W-1:0] nxt;
        logic [DATA_W-1:0] q;
        logic              b;

        always_comb begin
            hit = 1'b0;
            nxt = q;
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && wa_a[j] == ADDR) begin
                    hit = 1'b1;
                    nxt = wd_a[j];
                end
            end
        end

        // A reserve in the same cycle as a write wins: the newer producer
        // is still outstanding.
        always_ff @(posedge clk) begin
            if (reset) begin
                q <= '0;
                b <= 1'b0;
            end else begin
                if (hit) begin
                    q <= nxt;
                end
                if (rsv_en && rsv_addr == ADDR) begin
                    b <= 1'b1;
                end else if (hit) begin
                    b <= 1'b0;
                end
            end
        end

        assign regs[r]      = q;
        assign busy_bits[r] = b;
    end

    // Read ports. R_PC never bypasses and is never busy.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] val;
        logic              bsy;

        assign a = ra[i*ADDR_W +: ADDR_W];

        always_comb begin
            val = pc;
            bsy = 1'b0;
            if (a != R_PC) begin
                val = regs[a];
                bsy = busy_bits[a];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (we[j] && wa_a[j] == a) begin
                            val = wd_a[j];
                            // A same-cycle reserve keeps the stored bit.
                            if (!(rsv_en && rsv_addr == a)) begin
                                bsy = 1'b0;
                            end
                        end
                    end
                end
            end
        end

        assign rd[i*DATA_W +: DATA_W] = val;
        assign busy[i]                = bsy;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning register address width; address 2^ADDR_W-1 is the PC alias (R_PC).
REQ-003 The block SHALL have parameter NRD, default 3, meaning number of read ports.
REQ-004 The block SHALL have parameter NWR, default 2, meaning number of write ports.
REQ-005 The block SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding and 0 = reads return stored value only.
REQ-006 The block SHALL have port clk, input, 1 bit: the only clock; all state updates occur on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port ra, input, NRD*ADDR_W bits: read addresses, where port i is bits [i*ADDR_W +: ADDR_W].
REQ-009 The block SHALL have port rd, output, NRD*DATA_W bits: read data, packed in the same order as ra.
REQ-010 The block SHALL have port we, input, NWR bits: write enables.
REQ-011 The block SHALL have port wa, input, NWR*ADDR_W bits: write addresses.
REQ-012 The block SHALL have port wd, input, NWR*DATA_W bits: write data.
REQ-013 The block SHALL have port pc, input, DATA_W bits: value returned for reads of R_PC.
REQ-014 The block SHALL have port rsv_en, input, 1 bit: reserve a register as pending-write.
REQ-015 The block SHALL have port rsv_addr, input, ADDR_W bits: register to reserve.
REQ-016 The block SHALL have port busy, output, NRD bits: busy[i] = the register addressed by ra port i is reserved and not yet written.
REQ-017 The block SHALL have port wconflict, output, 1 bit: registered flag, asserted for 1 cycle after two or more enabled write ports targeted the same address.
REQ-018 The block SHALL have port pcwrite, output, 1 bit: registered flag, asserted for 1 cycle after any enabled write targeted R_PC.

Function
REQ-019 Storage SHALL be 2^ADDR_W-1 registers of DATA_W bits; R_PC SHALL NOT be stored.
REQ-020 Reads SHALL be combinational; ra port i = R_PC SHALL give rd port i = pc regardless of writes or bypass.
REQ-021 An enabled write port with wa != R_PC SHALL update the register at the rising edge; a write to R_PC SHALL be discarded and set pcwrite.
REQ-022 When several enabled ports write one address in a cycle, the highest-index port SHALL win, and wconflict SHALL be 1 in the next cycle.
REQ-023 With BYPASS=1, a read whose address matches an enabled write (not R_PC) in the same cycle SHALL return that write's wd, with the REQ-022 priority applied; with BYPASS=0, the read SHALL return the pre-edge stored value.
REQ-024 The scoreboard SHALL hold one busy bit per stored register; rsv_en SHALL set bit rsv_addr at the edge; rsv_addr = R_PC SHALL be ignored.
REQ-025 An enabled write SHALL clear the busy bit of its address at the edge.
REQ-026 A reserve and a write to the same address in the same cycle SHALL leave the bit set, because the newer producer wins.
REQ-027 busy[i] SHALL be the current busy bit of ra port i, 0 for R_PC; with BYPASS=1, a same-cycle write to that address SHALL force busy[i]=0 unless REQ-026 applies.
REQ-028 Widths: no arithmetic is performed; all data paths SHALL be exactly DATA_W bits, and no truncation or extension is allowed.
REQ-029 The block SHALL support NRD >= 1, NWR >= 1 and ADDR_W >= 2 without code edits.

Reset
REQ-030 When reset=1 at a rising edge, all stored registers SHALL become 0, all busy bits 0, and wconflict and pcwrite 0.
REQ-031 Reset SHALL take priority over we and rsv_en in the same cycle; those writes and reserves SHALL be dropped.
REQ-032 While reset is high, rd SHALL still reflect the combinational read path; after the first reset edge, non-PC reads SHALL return 0 (or bypassed data when BYPASS=1).

Verification
REQ-033 The bench SHALL cover reset, then we[0]=1, wa0=3, wd0=0xDEADBEEF; next cycle ra0=3 -> rd0=0xDEADBEEF, busy[0]=0.
REQ-034 The bench SHALL cover the same cycle we0/wa0=5/wd0=0x11 and we1/wa1=5/wd1=0x22, with ra1=5 and BYPASS=1 -> rd1=0x22 that cycle, R5=0x22 after the edge, and wconflict=1 for one cycle.
REQ-035 The bench SHALL cover ra2=15 with pc=0x100 and we0 to wa=15 with wd=0x55 -> rd2=0x100 both cycles, pcwrite=1 next cycle, and no register changed.
REQ-036 The bench SHALL cover rsv_en with rsv_addr=7, then ra0=7 -> busy[0]=1; a write to 7 in a later cycle gives busy[0]=0 that cycle (BYPASS=1) and after the edge; a simultaneous reserve and write to 7 leaves busy=1.
REQ-037 The bench SHALL cover BYPASS=0 with R2=0xA, writing 0xB to 2 while reading 2 -> rd=0xA that cycle and 0xB next.
REQ-038 The bench SHALL cover reset asserted mid-stream with we0=1, wa0=4 and rsv_en=1 for register 4 -> after the edge R4=0, busy=0, and flags=0.
